button_pulse_conditioner: RTL and testbench
===========================================

BUTTON_PULSE_CONDITIONER -- requirements
Module: button_pulse_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive stable synchronized samples (legal range 1..255) required to accept a level change.
REQ-002 Port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 Port btn_zero_raw, input, 1 bit: asynchronous, bouncing "0" pushbutton level, 1 = pressed.
REQ-005 Port btn_one_raw, input, 1 bit: asynchronous, bouncing "1" pushbutton level, 1 = pressed.
REQ-006 Port zero, output, 1 bit: registered single-cycle pulse per accepted "0" press; drives the combination lock zero input.
REQ-007 Port one, output, 1 bit: registered single-cycle pulse per accepted "1" press; drives the combination lock one input.
REQ-008 Port conflict, output, 1 bit: registered single-cycle pulse when both presses are accepted in the same cycle.
REQ-009 Port busy, output, 1 bit: high while either debounced level is 1.

Function
REQ-010 Each raw input SHALL pass through its own two-flop synchronizer; no other logic SHALL read raw inputs.
REQ-011 Each channel SHALL hold a debounced level and an 8-bit stability counter.
REQ-012 Counter SHALL clear on any cycle where synchronized value equals debounced level.
REQ-013 Counter SHALL increment on any cycle where synchronized value differs from debounced level.
REQ-014 When the counter would reach DEBOUNCE_CYCLES, the debounced level SHALL take the synchronized value and the counter SHALL clear in that same edge.
REQ-015 Each channel SHALL be a two-state FSM: RELEASED (debounced 0) and HELD (debounced 1); RELEASED->HELD produces a one-cycle press event; HELD->RELEASED produces no event.
REQ-016 A glitch or bounce shorter than DEBOUNCE_CYCLES synchronized cycles SHALL cause no level change and no pulse.
REQ-017 Holding a button indefinitely SHALL produce exactly one pulse; no auto-repeat.
REQ-018 Output register: press_zero only -> zero=1; press_one only -> one=1; both in same cycle -> zero=0, one=0, conflict=1; neither -> all 0.
REQ-019 zero and one SHALL never be 1 in the same cycle.
REQ-020 Latency: raw step first sampled at edge k and held stable -> debounced level changes at edge k+1+DEBOUNCE_CYCLES, output pulse high for exactly the one cycle following edge k+2+DEBOUNCE_CYCLES.
REQ-021 A press on one channel while the other is HELD SHALL be accepted normally; only same-cycle press events conflict.
REQ-022 busy SHALL be the OR of the two debounced levels, with no additional latency beyond those registers.

Reset
REQ-023 While rst=1, synchronizer flops, counters, debounced levels, zero, one and conflict SHALL all be 0 and busy SHALL be 0, independent of clk.
REQ-024 Reset asserted mid-debounce or mid-hold SHALL discard all progress; if a button is still pressed after rst deasserts, it SHALL be re-debounced from RELEASED and SHALL produce one pulse per REQ-020.
REQ-025 A pulse in flight when rst asserts SHALL be cleared immediately, not completed.

Verification
REQ-026 DEBOUNCE_CYCLES=4, btn_zero_raw 0->1 at edge 10 and held -> zero=1 only in cycle after edge 16, busy=1 from edge 15, one=conflict=0 throughout.
REQ-027 btn_one_raw bounces 1,0,1,0 on alternating cycles, then stable 1 -> no pulse during bounce; exactly one "one" pulse 6 cycles after last stable-start edge.
REQ-028 btn_one_raw high for 3 cycles only (< DEBOUNCE_CYCLES) -> one stays 0, busy stays 0.
REQ-029 Both raw inputs rise at the same edge and are held -> conflict=1 for one cycle, zero=one=0 throughout; releasing both produces no pulses.
REQ-030 btn_zero_raw held, pulse seen, then rst pulsed for 2 cycles with button still held -> all outputs 0 during reset; one new zero pulse 6 cycles after first post-reset sampling edge.
REQ-031 Feed press sequence 0,1,0,1,1 (each press 10 cycles, 10-cycle gaps) into the downstream combination lock -> exactly five pulses in order and the lock reports unlocked=1.

Source files
------------

// File: rtl/button_pulse_conditioner.sv
// Conditions two bouncing pushbuttons into single-cycle "zero"/"one" pulses
// for a combination lock; simultaneous accepted presses are reported as conflict.
module button_pulse_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_zero_raw,
  input  logic btn_one_raw,
  output logic zero,
  output logic one,
  output logic conflict,
  output logic busy
);

  typedef enum logic {
    RELEASED = 1'b0,
    HELD     = 1'b1
  } state_t;

  localparam logic [7:0] LIMIT = 8'(DEBOUNCE_CYCLES);

  // Channel 0 is the "0" button, channel 1 the "1" button.
  logic [1:0] raw;
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] press;
  logic [7:0] cnt [2];
  state_t     state [2];

  assign raw = {btn_one_raw, btn_zero_raw};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Level change is accepted on the edge where the counter would reach LIMIT;
  // only RELEASED->HELD raises a press event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        cnt[i]   <= '0;
        state[i] <= RELEASED;
      end
    end else begin
      press <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == logic'(state[i])) begin
          cnt[i] <= '0;
        end else if (cnt[i] + 8'd1 == LIMIT) begin
          cnt[i] <= '0;
          if (state[i] == RELEASED) begin
            state[i] <= HELD;
            press[i] <= 1'b1;
          end else begin
            state[i] <= RELEASED;
          end
        end else begin
          cnt[i] <= cnt[i] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero     <= 1'b0;
      one      <= 1'b0;
      conflict <= 1'b0;
    end else begin
      zero     <= press[0] & ~press[1];
      one      <= press[1] & ~press[0];
      conflict <= press[0] & press[1];
    end
  end

  assign busy = (state[0] == HELD) | (state[1] == HELD);

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Scoreboard bench: expected pulses (kind, edge number) are queued as stimulus
// is driven and checked by a negedge monitor as the DUT emits them.
module tb_button_pulse_conditioner;

  localparam int D = 4;
  localparam logic [2:0] K_ZERO = 3'b001;
  localparam logic [2:0] K_ONE  = 3'b010;
  localparam logic [2:0] K_CONF = 3'b100;

  typedef struct {
    logic [2:0] kind;
    int         edge_n;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_zero_raw = 1'b0;
  logic btn_one_raw  = 1'b0;
  logic zero, one, conflict, busy;

  int asserts = 0;
  int fails   = 0;
  int cyc     = 0;
  exp_t exp_q[$];

  // Downstream combination lock: last five accepted digits must be 0,1,0,1,1.
  logic [4:0] lock_hist = '0;
  int         lock_count = 0;
  logic       lock_clr = 1'b0;
  logic       unlocked;
  assign unlocked = (lock_count >= 5) && (lock_hist == 5'b01011);

  button_pulse_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_zero_raw (btn_zero_raw),
    .btn_one_raw  (btn_one_raw),
    .zero         (zero),
    .one          (one),
    .conflict     (conflict),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (lock_clr) begin
      lock_hist  <= '0;
      lock_count <= 0;
    end else if (zero || one) begin
      lock_hist  <= {lock_hist[3:0], one};
      lock_count <= lock_count + 1;
    end
  end

  always @(negedge clk) begin
    logic [2:0] k;
    exp_t e;
    k = {conflict, one, zero};
    if (!rst && k != 3'b000) begin
      asserts++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: got kind=%b at edge %0d, required no pulse", k, cyc);
      end else begin
        e = exp_q.pop_front();
        if (k !== e.kind || cyc != e.edge_n) begin
          fails++;
          $display("FAIL pulse: got kind=%b at edge %0d, required kind=%b at edge %0d",
                   k, cyc, e.kind, e.edge_n);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    btn_zero_raw = 1'b1;
    btn_one_raw  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      asserts++;
      if ({zero, one, conflict, busy} !== 4'b0000) begin
        fails++;
        $display("FAIL reset_outputs: got %b, required 0000", {zero, one, conflict, busy});
      end
    end
    btn_zero_raw = 1'b0;
    btn_one_raw  = 1'b0;
    idle(1);
    rst = 1'b0;
    idle(8);
    asserts++;
    if ({zero, one, conflict, busy} !== 4'b0000) begin
      fails++;
      $display("FAIL idle_after_reset: got %b, required 0000", {zero, one, conflict, busy});
    end
  endtask

  task automatic test_single_zero;
    int c;
    logic eb;
    @(negedge clk);
    c = cyc;
    btn_zero_raw = 1'b1;
    exp_q.push_back('{K_ZERO, c + 3 + D});
    for (int i = 0; i < D + 40; i++) begin
      @(negedge clk);
      eb = (cyc >= c + 2 + D);
      asserts++;
      if (busy !== eb) begin
        fails++;
        $display("FAIL busy_zero_press: got %b at edge %0d, required %b", busy, cyc, eb);
      end
    end
    btn_zero_raw = 1'b0;
    idle(D + 6);
    asserts++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL busy_after_release: got %b, required 0", busy);
    end
    asserts++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL single_zero_pending: got %0d outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_bounce;
    int c;
    logic pat [4];
    pat = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      btn_one_raw = pat[i];
    end
    @(negedge clk);
    c = cyc;
    btn_one_raw = 1'b1;
    exp_q.push_back('{K_ONE, c + 3 + D});
    for (int i = 0; i < D + 1; i++) begin
      @(negedge clk);
      asserts++;
      if (busy !== 1'b0) begin
        fails++;
        $display("FAIL busy_during_bounce: got %b at edge %0d, required 0", busy, cyc);
      end
    end
    idle(20);
    btn_one_raw = 1'b0;
    idle(D + 6);
    asserts++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL bounce_pending: got %0d outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_short_glitch;
    int c;
    @(negedge clk);
    btn_one_raw = 1'b1;
    idle(D - 1);
    btn_one_raw = 1'b0;
    for (int i = 0; i < D + 8; i++) begin
      @(negedge clk);
      asserts++;
      if (busy !== 1'b0) begin
        fails++;
        $display("FAIL busy_short_glitch: got %b at edge %0d, required 0", busy, cyc);
      end
    end
    // Exactly DEBOUNCE_CYCLES stable samples is enough to be accepted.
    @(negedge clk);
    c = cyc;
    btn_one_raw = 1'b1;
    exp_q.push_back('{K_ONE, c + 3 + D});
    idle(D);
    btn_one_raw = 1'b0;
    idle(3 * D + 8);
    asserts++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL exact_threshold: got %0d outstanding busy=%b, required 0 outstanding busy=0",
               exp_q.size(), busy);
    end
  endtask

  task automatic test_conflict;
    int c;
    @(negedge clk);
    c = cyc;
    btn_zero_raw = 1'b1;
    btn_one_raw  = 1'b1;
    exp_q.push_back('{K_CONF, c + 3 + D});
    idle(D + 20);
    btn_zero_raw = 1'b0;
    btn_one_raw  = 1'b0;
    idle(D + 10);
    asserts++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL conflict_pending: got %0d outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_other_held;
    int c;
    @(negedge clk);
    c = cyc;
    btn_zero_raw = 1'b1;
    exp_q.push_back('{K_ZERO, c + 3 + D});
    idle(D + 10);
    @(negedge clk);
    c = cyc;
    btn_one_raw = 1'b1;
    exp_q.push_back('{K_ONE, c + 3 + D});
    idle(D + 10);
    btn_zero_raw = 1'b0;
    btn_one_raw  = 1'b0;
    idle(D + 10);
    asserts++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL other_held_pending: got %0d outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_hold;
    int c;
    @(negedge clk);
    c = cyc;
    btn_zero_raw = 1'b1;
    exp_q.push_back('{K_ZERO, c + 3 + D});
    while (cyc < c + 3 + D) @(negedge clk);
    // Pulse is high in this cycle; async reset must kill it immediately.
    #2;
    rst = 1'b1;
    #1;
    asserts++;
    if ({zero, one, conflict, busy} !== 4'b0000) begin
      fails++;
      $display("FAIL async_reset_clear: got %b, required 0000", {zero, one, conflict, busy});
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      asserts++;
      if ({zero, one, conflict, busy} !== 4'b0000) begin
        fails++;
        $display("FAIL reset_hold_outputs: got %b, required 0000", {zero, one, conflict, busy});
      end
    end
    c = cyc;
    rst = 1'b0;
    exp_q.push_back('{K_ZERO, c + 3 + D});
    idle(D + 12);
    btn_zero_raw = 1'b0;
    idle(D + 8);
    asserts++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL reset_rearm_pending: got %0d outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_lock_sequence;
    int c;
    logic seq [5];
    seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    @(negedge clk);
    lock_clr = 1'b1;
    @(negedge clk);
    lock_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      c = cyc;
      if (seq[i]) begin
        btn_one_raw = 1'b1;
        exp_q.push_back('{K_ONE, c + 3 + D});
      end else begin
        btn_zero_raw = 1'b1;
        exp_q.push_back('{K_ZERO, c + 3 + D});
      end
      idle(10);
      btn_zero_raw = 1'b0;
      btn_one_raw  = 1'b0;
      idle(10);
    end
    idle(D + 4);
    asserts++;
    if (lock_count != 5) begin
      fails++;
      $display("FAIL lock_pulse_count: got %0d, required 5", lock_count);
    end
    asserts++;
    if (unlocked !== 1'b1) begin
      fails++;
      $display("FAIL lock_unlocked: got %b (hist %b), required 1", unlocked, lock_hist);
    end
    asserts++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL lock_pending: got %0d outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_zero();
    test_bounce();
    test_short_glitch();
    test_conflict();
    test_other_held();
    test_reset_mid_hold();
    test_lock_sequence();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
